// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register-file port between requesters A and B.
// Write ack 2 cycles after sampled req, read ack 2+RF_READ_LATENCY; req held until ack.
module rf_port_arbiter #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5,
  parameter int RF_READ_LATENCY = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_rs1,
  input  logic [ADDR_W-1:0] a_rs2,
  input  logic [ADDR_W-1:0] a_wr_add,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_rs1,
  input  logic [ADDR_W-1:0] b_rs2,
  input  logic [ADDR_W-1:0] b_wr_add,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_ack,
  output logic              b_ack,
  output logic [DATA_W-1:0] a_rdata1,
  output logic [DATA_W-1:0] a_rdata2,
  output logic [DATA_W-1:0] b_rdata1,
  output logic [DATA_W-1:0] b_rdata2,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count,
  output logic              RF_chip_enable,
  output logic              RF_write_enable,
  output logic [ADDR_W-1:0] RF_rs1_address,
  output logic [ADDR_W-1:0] RF_rs2_address,
  output logic [ADDR_W-1:0] RF_WR_add,
  output logic [DATA_W-1:0] RF_WriteData,
  input  logic [DATA_W-1:0] RF_reg1_data,
  input  logic [DATA_W-1:0] RF_reg2_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [1:0]        wcnt_q, wcnt_d;

  always_comb begin
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    we_d     = we_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    wr_d     = wr_q;
    wd_d     = wd_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // On a tie the port that did not win last time is granted.
          gnt_b_d  = b_req && (!a_req || !last_b_q);
          last_b_d = gnt_b_d;
          we_d     = gnt_b_d ? b_we     : a_we;
          rs1_d    = gnt_b_d ? b_rs1    : a_rs1;
          rs2_d    = gnt_b_d ? b_rs2    : a_rs2;
          wr_d     = gnt_b_d ? b_wr_add : a_wr_add;
          wd_d     = gnt_b_d ? b_wdata  : a_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          wcnt_d  = 2'(RF_READ_LATENCY);
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 2'd1;
        if (wcnt_q == 2'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      wr_q     <= '0;
      wd_q     <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  logic              issue_d, resp_d, capture;
  logic [DATA_W-1:0] rd1, rd2;
  assign issue_d = (state_d == ISSUE);
  assign resp_d  = (state_d == RESP);
  assign capture = (state_q == WAIT) && (wcnt_q == 2'd1);
  assign rd1     = (rs1_q == '0) ? '0 : RF_reg1_data;
  assign rd2     = (rs2_q == '0) ? '0 : RF_reg2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack           <= 1'b0;
      b_ack           <= 1'b0;
      a_rdata1        <= '0;
      a_rdata2        <= '0;
      b_rdata1        <= '0;
      b_rdata2        <= '0;
      a_count         <= '0;
      b_count         <= '0;
      RF_chip_enable  <= 1'b0;
      RF_write_enable <= 1'b0;
      RF_rs1_address  <= '0;
      RF_rs2_address  <= '0;
      RF_WR_add       <= '0;
      RF_WriteData    <= '0;
    end else begin
      RF_chip_enable  <= issue_d && !(we_d && (wr_d == '0));
      RF_write_enable <= issue_d && we_d;
      RF_rs1_address  <= issue_d ? rs1_d : '0;
      RF_rs2_address  <= issue_d ? rs2_d : '0;
      RF_WR_add       <= issue_d ? wr_d  : '0;
      RF_WriteData    <= issue_d ? wd_d  : '0;
      a_ack           <= resp_d && !gnt_b_d;
      b_ack           <= resp_d && gnt_b_d;
      if (resp_d && !gnt_b_d) a_count <= a_count + CNT_W'(1);
      if (resp_d && gnt_b_d)  b_count <= b_count + CNT_W'(1);
      if (capture) begin
        if (gnt_b_q) begin
          b_rdata1 <= rd1;
          b_rdata2 <= rd2;
        end else begin
          a_rdata1 <= rd1;
          a_rdata2 <= rd2;
        end
      end
    end
  end

endmodule
